shot_exchange_ctl: RTL and testbench

//  Sequences one battleship shot exchange between the two boards over the byte link (UART side).

---
 rtl/shot_exchange_ctl.sv | 196 +++++++++++++++++++
 tb/tb_shot_exchange_ctl.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shot_exchange_ctl.sv
// Shot exchange sequencer for the battleship byte link: sends own shots with retry on timeout,
// and answers incoming shots from the local ship board.
module shot_exchange_ctl #(
  parameter int unsigned TIMEOUT_CYC = 65_000_000,
  parameter int unsigned RETRY_MAX   = 3,
  parameter logic [7:0]  HDR_SHOT    = 8'hA5,
  parameter logic [7:0]  HDR_ANS     = 8'hC3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_fire_req,
  input  logic [7:0] i_fire_pos,
  output logic [7:0] o_tx_data,
  output logic       o_tx_valid,
  input  logic       i_tx_ready,
  input  logic [7:0] i_rx_data,
  input  logic       i_rx_valid,
  output logic       o_board_rd_en,
  output logic [7:0] o_board_rd_addr,
  input  logic       i_board_rd_data,
  output logic       o_busy,
  output logic       o_shot_done,
  output logic       o_shot_hit,
  output logic       o_rx_shot_done,
  output logic [7:0] o_rx_shot_pos,
  output logic       o_rx_shot_hit,
  output logic       o_bad_pos,
  output logic       o_link_err
);

  localparam int unsigned CntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RtyW = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1;

  typedef enum logic [3:0] {
    StIdle, StTxShH, StTxShP, StWtAH, StWtAV, StRxPos, StLookup, StLkWait, StTxAnH, StTxAnV
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [RtyW-1:0] r_retry;
  logic [7:0]      r_pos;
  logic [7:0]      r_tx_data;
  logic            r_tx_valid;
  logic            r_board_rd_en;
  logic [7:0]      r_board_rd_addr;
  logic            r_busy;
  logic            r_shot_done;
  logic            r_shot_hit;
  logic            r_rx_shot_done;
  logic [7:0]      r_rx_shot_pos;
  logic            r_rx_shot_hit;
  logic            r_bad_pos;
  logic            r_link_err;

  logic w_rx_shot_hdr;
  logic w_fire_ok;
  logic w_rx_pos_ok;
  logic w_ans_ok;
  logic w_expired;

  assign w_rx_shot_hdr = i_rx_valid && (i_rx_data == HDR_SHOT);
  assign w_fire_ok     = (i_fire_pos[7:4] <= 4'd9) && (i_fire_pos[3:0] <= 4'd9);
  assign w_rx_pos_ok   = (i_rx_data[7:4] <= 4'd9) && (i_rx_data[3:0] <= 4'd9);
  assign w_ans_ok      = i_rx_valid && (i_rx_data[7:1] == 7'd0);
  assign w_expired     = (r_cnt == CntW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= StIdle;
      r_cnt           <= '0;
      r_retry         <= '0;
      r_pos           <= '0;
      r_tx_data       <= '0;
      r_tx_valid      <= 1'b0;
      r_board_rd_en   <= 1'b0;
      r_board_rd_addr <= '0;
      r_busy          <= 1'b0;
      r_shot_done     <= 1'b0;
      r_shot_hit      <= 1'b0;
      r_rx_shot_done  <= 1'b0;
      r_rx_shot_pos   <= '0;
      r_rx_shot_hit   <= 1'b0;
      r_bad_pos       <= 1'b0;
      r_link_err      <= 1'b0;
    end else begin
      r_shot_done    <= 1'b0;
      r_rx_shot_done <= 1'b0;
      r_bad_pos      <= 1'b0;
      r_link_err     <= 1'b0;
      r_board_rd_en  <= 1'b0;
      case (r_state)
        StIdle: begin
          // An incoming shot has priority; a simultaneous fire request is dropped.
          if (w_rx_shot_hdr) begin
            r_state <= StRxPos;
            r_busy  <= 1'b1;
          end else if (i_fire_req) begin
            if (w_fire_ok) begin
              r_pos      <= i_fire_pos;
              r_retry    <= '0;
              r_state    <= StTxShH;
              r_busy     <= 1'b1;
              r_tx_valid <= 1'b1;
              r_tx_data  <= HDR_SHOT;
            end else begin
              r_bad_pos <= 1'b1;
            end
          end
        end
        StTxShH: if (i_tx_ready) begin
          r_state   <= StTxShP;
          r_tx_data <= r_pos;
        end
        StTxShP: if (i_tx_ready) begin
          r_state    <= StWtAH;
          r_tx_valid <= 1'b0;
          r_tx_data  <= '0;
          r_cnt      <= '0;
        end
        StWtAH, StWtAV: begin
          // A completing answer byte wins over timeout expiry in the same cycle.
          if ((r_state == StWtAV) && w_ans_ok) begin
            r_state     <= StIdle;
            r_busy      <= 1'b0;
            r_shot_hit  <= i_rx_data[0];
            r_shot_done <= 1'b1;
          end else if (w_expired) begin
            if (r_retry < RtyW'(RETRY_MAX)) begin
              r_retry    <= r_retry + RtyW'(1);
              r_state    <= StTxShH;
              r_tx_valid <= 1'b1;
              r_tx_data  <= HDR_SHOT;
            end else begin
              r_link_err <= 1'b1;
              r_state    <= StIdle;
              r_busy     <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt + CntW'(1);
            if (i_rx_valid) begin
              r_state <= ((r_state == StWtAH) && (i_rx_data == HDR_ANS)) ? StWtAV : StWtAH;
            end
          end
        end
        StRxPos: if (i_rx_valid) begin
          if (w_rx_pos_ok) begin
            r_state         <= StLookup;
            r_rx_shot_pos   <= i_rx_data;
            r_board_rd_en   <= 1'b1;
            r_board_rd_addr <= i_rx_data;
          end else begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end
        end
        StLookup: r_state <= StLkWait;
        StLkWait: begin
          r_rx_shot_hit <= i_board_rd_data;
          r_state       <= StTxAnH;
          r_tx_valid    <= 1'b1;
          r_tx_data     <= HDR_ANS;
        end
        StTxAnH: if (i_tx_ready) begin
          r_state   <= StTxAnV;
          r_tx_data <= {7'd0, r_rx_shot_hit};
        end
        StTxAnV: if (i_tx_ready) begin
          r_state        <= StIdle;
          r_busy         <= 1'b0;
          r_tx_valid     <= 1'b0;
          r_tx_data      <= '0;
          r_rx_shot_done <= 1'b1;
        end
        default: begin
          r_state    <= StIdle;
          r_busy     <= 1'b0;
          r_tx_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_data       = r_tx_data;
  assign o_tx_valid      = r_tx_valid;
  assign o_board_rd_en   = r_board_rd_en;
  assign o_board_rd_addr = r_board_rd_addr;
  assign o_busy          = r_busy;
  assign o_shot_done     = r_shot_done;
  assign o_shot_hit      = r_shot_hit;
  assign o_rx_shot_done  = r_rx_shot_done;
  assign o_rx_shot_pos   = r_rx_shot_pos;
  assign o_rx_shot_hit   = r_rx_shot_hit;
  assign o_bad_pos       = r_bad_pos;
  assign o_link_err      = r_link_err;

endmodule

// File: tb/tb_shot_exchange_ctl.sv
// Scoreboard bench for shot_exchange_ctl: stimulus pushes expected tx bytes and pulse events,
// a negedge monitor pops and compares them as the DUT produces them.
module tb_shot_exchange_ctl;

  localparam int unsigned TO   = 100;
  localparam int unsigned RMAX = 3;
  localparam logic [7:0]  HS   = 8'hA5;
  localparam logic [7:0]  HA   = 8'hC3;
  localparam int KShot = 0, KRx = 1, KBad = 2, KLink = 3, KRd = 4;

  typedef struct {
    int         kind;
    logic [8:0] val;
  } evt_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       fire_req = 1'b0;
  logic [7:0] fire_pos = '0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       board_rd_en;
  logic [7:0] board_rd_addr;
  logic       board_rd_data = 1'b0;
  logic       busy, shot_done, shot_hit, rx_shot_done, rx_shot_hit, bad_pos, link_err;
  logic [7:0] rx_shot_pos;

  shot_exchange_ctl #(.TIMEOUT_CYC(TO), .RETRY_MAX(RMAX), .HDR_SHOT(HS), .HDR_ANS(HA)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_fire_req     (fire_req),
    .i_fire_pos     (fire_pos),
    .o_tx_data      (tx_data),
    .o_tx_valid     (tx_valid),
    .i_tx_ready     (tx_ready),
    .i_rx_data      (rx_data),
    .i_rx_valid     (rx_valid),
    .o_board_rd_en  (board_rd_en),
    .o_board_rd_addr(board_rd_addr),
    .i_board_rd_data(board_rd_data),
    .o_busy         (busy),
    .o_shot_done    (shot_done),
    .o_shot_hit     (shot_hit),
    .o_rx_shot_done (rx_shot_done),
    .o_rx_shot_pos  (rx_shot_pos),
    .o_rx_shot_hit  (rx_shot_hit),
    .o_bad_pos      (bad_pos),
    .o_link_err     (link_err)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic       board_mem [256];
  logic [7:0] exp_tx [$];
  evt_t       exp_evt [$];
  logic       rdy_force_en = 1'b1;
  logic       rdy_force = 1'b1;
  logic       expect_to = 1'b0;
  logic       wait_arm = 1'b0;
  int         hs_edge = 0;
  logic       prev_v = 1'b0;
  logic       prev_r = 1'b0;
  logic [7:0] prev_d = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic bit pos_ok(input logic [7:0] p);
    return (p[7:4] <= 4'd9) && (p[3:0] <= 4'd9);
  endfunction

  function automatic evt_t mk(input int k, input logic [8:0] v);
    evt_t e;
    e.kind = k;
    e.val  = v;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Registered board RAM: data valid the cycle after the read strobe.
  always @(posedge clk) if (board_rd_en) board_rd_data <= board_mem[board_rd_addr];

  initial forever begin
    @(posedge clk);
    #2;
    tx_ready = rdy_force_en ? rdy_force : ($urandom_range(0, 3) != 0);
  end

  task automatic take_evt(input int kind, input logic [8:0] val, input string nm);
    evt_t e;
    chk({nm, " expected"}, 32'(exp_evt.size() != 0), 32'd1);
    if (exp_evt.size() != 0) begin
      e = exp_evt.pop_front();
      chk({nm, " kind"}, kind, e.kind);
      chk({nm, " value"}, 32'(val), 32'(e.val));
    end
  endtask

  // Monitor / scoreboard checker
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v   <= 1'b0;
      prev_r   <= 1'b0;
      prev_d   <= '0;
      wait_arm <= 1'b0;
    end else begin
      if (prev_v && !prev_r) begin
        chk("tx hold valid", 32'(tx_valid), 32'd1);
        chk("tx hold data", 32'(tx_data), 32'(prev_d));
      end
      // Retransmission must start TO cycles after the pos byte was accepted.
      if (wait_arm && tx_valid && !prev_v) begin
        chk("retx gap", cyc - hs_edge, TO);
        wait_arm <= 1'b0;
      end
      if (tx_valid && tx_ready) begin
        chk("tx byte expected", 32'(exp_tx.size() != 0), 32'd1);
        if (exp_tx.size() != 0) chk("tx byte", 32'(tx_data), 32'(exp_tx.pop_front()));
        if (expect_to && tx_data != HS) begin
          wait_arm <= 1'b1;
          hs_edge  <= cyc + 1;
        end
      end
      if (shot_done)    take_evt(KShot, {8'd0, shot_hit}, "shot_done");
      if (rx_shot_done) take_evt(KRx, {rx_shot_hit, rx_shot_pos}, "rx_shot_done");
      if (bad_pos)      take_evt(KBad, 9'd0, "bad_pos");
      if (board_rd_en)  take_evt(KRd, {1'b0, board_rd_addr}, "board_rd");
      if (link_err) begin
        take_evt(KLink, 9'd0, "link_err");
        if (wait_arm) begin
          chk("link_err gap", cyc - hs_edge, TO);
          wait_arm <= 1'b0;
        end
      end
      prev_v <= tx_valid;
      prev_r <= tx_ready;
      prev_d <= tx_data;
    end
  end

  task automatic cycle1();
    @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [7:0] b);
    int g;
    rx_data  = b;
    rx_valid = 1'b1;
    cycle1();
    rx_valid = 1'b0;
    g = $urandom_range(0, 2);
    for (int i = 0; i < g; i++) cycle1();
  endtask

  task automatic wait_tx_drain(input int budget);
    int n = 0;
    while (exp_tx.size() != 0 && n < budget) begin
      cycle1();
      n++;
    end
    chk("tx drain", exp_tx.size(), 0);
  endtask

  task automatic finish_txn(input string nm);
    int n = 0;
    cycle1();
    while (busy && n < 2000) begin
      cycle1();
      n++;
    end
    chk({nm, " back to idle"}, 32'(busy), 32'd0);
    cycle1();
    cycle1();
    chk({nm, " tx left"}, exp_tx.size(), 0);
    chk({nm, " events left"}, exp_evt.size(), 0);
    exp_tx.delete();
    exp_evt.delete();
  endtask

  // ans: 0 miss, 1 hit, 2 never answered
  task automatic do_fire(input logic [7:0] p, input int ans, input bit use_junk,
                         input logic [7:0] junk, input bit stray);
    logic [7:0] b;
    if (!pos_ok(p)) begin
      exp_evt.push_back(mk(KBad, 9'd0));
      fire_pos = p;
      fire_req = 1'b1;
      cycle1();
      fire_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
        chk("bad_pos busy", 32'(busy), 32'd0);
        cycle1();
      end
    end else begin
      if (ans == 2) begin
        expect_to = 1'b1;
        for (int i = 0; i <= int'(RMAX); i++) begin
          exp_tx.push_back(HS);
          exp_tx.push_back(p);
        end
        exp_evt.push_back(mk(KLink, 9'd0));
      end else begin
        exp_tx.push_back(HS);
        exp_tx.push_back(p);
      end
      fire_pos = p;
      fire_req = 1'b1;
      cycle1();
      fire_req = 1'b0;
      if (ans != 2) begin
        wait_tx_drain(200);
        if (stray) begin
          b = 8'($urandom);
          if (b == HA) b = 8'h00;
          send_rx(b);
        end
        send_rx(HA);
        if (use_junk) begin
          send_rx(junk);
          send_rx(HA);
        end
        exp_evt.push_back(mk(KShot, 9'(ans)));
        send_rx(8'(ans));
      end
    end
    finish_txn("fire");
    expect_to = 1'b0;
  endtask

  task automatic do_incoming(input logic [7:0] p, input bit with_fire, input logic [7:0] fpos);
    int g;
    if (pos_ok(p)) begin
      exp_evt.push_back(mk(KRd, {1'b0, p}));
      exp_tx.push_back(HA);
      exp_tx.push_back({7'd0, board_mem[p]});
      exp_evt.push_back(mk(KRx, {board_mem[p], p}));
    end
    rx_data  = HS;
    rx_valid = 1'b1;
    fire_req = with_fire;
    fire_pos = fpos;
    cycle1();
    rx_valid = 1'b0;
    fire_req = 1'b0;
    g = $urandom_range(0, 3);
    for (int i = 0; i < g; i++) cycle1();
    send_rx(p);
    finish_txn("incoming");
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, " a"}, 32'({tx_valid, tx_data, board_rd_en, board_rd_addr, busy}), 32'd0);
    chk({nm, " b"}, 32'({shot_done, shot_hit, rx_shot_done, rx_shot_pos, rx_shot_hit, bad_pos,
                         link_err}), 32'd0);
  endtask

  initial begin
    logic [7:0] p;
    logic [7:0] b;
    for (int i = 0; i < 256; i++) board_mem[i] = 1'($urandom_range(0, 1));
    board_mem[8'h27] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset outputs");
    rst_n = 1'b1;
    cycle1();

    do_fire(8'h34, 1, 1'b0, 8'h00, 1'b0);
    chk("shot_hit held", 32'(shot_hit), 32'd1);
    do_fire(8'h3A, 0, 1'b0, 8'h00, 1'b0);
    do_incoming(8'h27, 1'b0, 8'h00);
    chk("rx_shot_pos held", 32'(rx_shot_pos), 32'h27);
    chk("rx_shot_hit held", 32'(rx_shot_hit), 32'd0);

    rdy_force_en = 1'b0;
    do_fire(8'h56, 2, 1'b0, 8'h00, 1'b0);
    do_incoming(8'h81, 1'b1, 8'h12);
    do_fire(8'h99, 0, 1'b1, 8'h07, 1'b0);
    chk("shot_hit after junk", 32'(shot_hit), 32'd0);
    do_fire(8'hA0, 0, 1'b0, 8'h00, 1'b0);

    // Reset while the position byte is waiting for tx_ready.
    rdy_force_en = 1'b1;
    rdy_force    = 1'b1;
    cycle1();
    exp_tx.push_back(HS);
    fire_pos = 8'h45;
    fire_req = 1'b1;
    cycle1();
    fire_req = 1'b0;
    @(posedge clk);
    #1;
    rdy_force = 1'b0;
    #2;
    chk("mid-frame tx_valid", 32'(tx_valid), 32'd1);
    chk("mid-frame tx_data", 32'(tx_data), 32'h45);
    rst_n = 1'b0;
    #1;
    check_all_zero("async reset");
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("held reset");
    chk("reset tx left", exp_tx.size(), 0);
    exp_tx.delete();
    exp_evt.delete();
    rst_n = 1'b1;
    rdy_force_en = 1'b0;
    cycle1();

    for (int t = 0; t < 40; t++) begin
      p = {4'($urandom_range(0, 11)), 4'($urandom_range(0, 11))};
      case ($urandom_range(0, 3))
        0, 1: do_fire(p, int'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0),
                      8'h02 + 8'($urandom_range(0, 253)), 1'($urandom_range(0, 1)));
        2: do_incoming(p, 1'b0, 8'h00);
        default: begin
          b = 8'($urandom);
          if (b == HS) b = 8'h5A;
          send_rx(b);
          chk("stray byte idle", 32'(busy), 32'd0);
          finish_txn("stray");
        end
      endcase
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
